iob2axil: RTL and testbench

IOB2AXIL -- requirements
Module: iob2axil

---
 rtl/iob2axil.sv | 157 +++++++++++++++
 tb/tb_iob2axil.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge. One transaction in flight; the AXI
// payload is registered at accept time and AW/W handshakes are tracked separately.
module iob2axil #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cke_i,
  input  logic                       iob_avalid_i,
  input  logic [AXIL_ADDR_W-1:0]     iob_addr_i,
  input  logic [AXIL_DATA_W-1:0]     iob_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0]   iob_wstrb_i,
  output logic                       iob_rvalid_o,
  output logic [AXIL_DATA_W-1:0]     iob_rdata_o,
  output logic                       iob_ready_o,
  output logic [AXIL_ADDR_W-1:0]     axil_awaddr_o,
  output logic [2:0]                 axil_awprot_o,
  output logic                       axil_awvalid_o,
  input  logic                       axil_awready_i,
  output logic [AXIL_DATA_W-1:0]     axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0]   axil_wstrb_o,
  output logic                       axil_wvalid_o,
  input  logic                       axil_wready_i,
  input  logic [1:0]                 axil_bresp_i,
  input  logic                       axil_bvalid_i,
  output logic                       axil_bready_o,
  output logic [AXIL_ADDR_W-1:0]     axil_araddr_o,
  output logic [2:0]                 axil_arprot_o,
  output logic                       axil_arvalid_o,
  input  logic                       axil_arready_i,
  input  logic [AXIL_DATA_W-1:0]     axil_rdata_i,
  input  logic [1:0]                 axil_rresp_i,
  input  logic                       axil_rvalid_i,
  output logic                       axil_rready_o,
  output logic                       err_o
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     rvalid_q, rvalid_d;
  logic                     err_q, err_d;
  logic [AXIL_DATA_W-1:0]   rdata_q, rdata_d;
  logic [AXIL_ADDR_W-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;

  // Control state: reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else if (cke_i) begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request payload needs no reset: it is only visible behind a valid.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      IDLE: begin
        if (iob_avalid_i) begin
          addr_d    = iob_addr_i;
          wdata_d   = iob_wdata_i;
          wstrb_d   = iob_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|iob_wstrb_i) ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // A flag that is already set keeps its valid low, so a stray ready is harmless.
        aw_done_d = aw_done_q | axil_awready_i;
        w_done_d  = w_done_q | axil_wready_i;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axil_bvalid_i) begin
          err_d   = |axil_bresp_i;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (axil_arready_i) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axil_rvalid_i) begin
          rdata_d  = axil_rdata_i;
          rvalid_d = 1'b1;
          err_d    = |axil_rresp_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iob_ready_o    = (state_q == IDLE);
  assign iob_rvalid_o   = rvalid_q;
  assign iob_rdata_o    = rdata_q;
  assign err_o          = err_q;

  assign axil_awaddr_o  = addr_q;
  assign axil_awprot_o  = 3'b000;
  assign axil_awvalid_o = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign axil_wdata_o   = wdata_q;
  assign axil_wstrb_o   = wstrb_q;
  assign axil_wvalid_o  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign axil_bready_o  = (state_q == WR_RESP);

  assign axil_araddr_o  = addr_q;
  assign axil_arprot_o  = 3'b000;
  assign axil_arvalid_o = (state_q == RD_ADDR);
  assign axil_rready_o  = (state_q == RD_DATA);

endmodule

// File: tb/tb_iob2axil.sv
// Bench for iob2axil: an AXI4-Lite slave model with random ready/response timing
// and a transaction scoreboard comparing IOb requests with what the slave saw.
module tb_iob2axil;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cke;
  logic iob_avalid, iob_rvalid, iob_ready;
  logic [AW-1:0] iob_addr;
  logic [DW-1:0] iob_wdata, iob_rdata;
  logic [SW-1:0] iob_wstrb;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, err;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp, rresp;

  iob2axil #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .iob_avalid_i(iob_avalid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
    .iob_wstrb_i(iob_wstrb), .iob_rvalid_o(iob_rvalid), .iob_rdata_o(iob_rdata),
    .iob_ready_o(iob_ready),
    .axil_awaddr_o(awaddr), .axil_awprot_o(awprot), .axil_awvalid_o(awvalid),
    .axil_awready_i(awready), .axil_wdata_o(wdata), .axil_wstrb_o(wstrb),
    .axil_wvalid_o(wvalid), .axil_wready_i(wready), .axil_bresp_i(bresp),
    .axil_bvalid_i(bvalid), .axil_bready_o(bready),
    .axil_araddr_o(araddr), .axil_arprot_o(arprot), .axil_arvalid_o(arvalid),
    .axil_arready_i(arready), .axil_rdata_i(rdata), .axil_rresp_i(rresp),
    .axil_rvalid_i(rvalid), .axil_rready_o(rready), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave knobs, set by the main sequence.
  int unsigned rdy_pct = 100;
  int dly_min = 0, dly_max = 0, w_lag = 0;
  bit ar_hold = 1'b0;
  bit rd_fixed_en = 1'b0;
  logic [DW-1:0] rd_fixed = '0;
  logic [1:0] b_resp_plan = 2'b00, r_resp_plan = 2'b00;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; logic [1:0] resp; } wr_t;
  typedef struct packed { logic [DW-1:0] d; logic [1:0] resp; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int aw_cnt = 0, ar_cnt = 0;
  logic [DW-1:0] last_rd = '0;

  // AXI slave: acts just after each falling edge, for the next rising edge.
  initial begin : axi_slave
    logic s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_en, s_rst;
    logic [AW-1:0] s_awaddr, s_araddr, c_a;
    logic [DW-1:0] s_wdata, c_d;
    logic [SW-1:0] s_wstrb, c_s;
    logic got_aw, got_w, b_pend, r_pend;
    int b_wait, r_wait, aw_age;
    {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_en, s_rst} = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    c_a = '0; c_d = '0; c_s = '0;
    {got_aw, got_w, b_pend, r_pend} = '0;
    b_wait = 0; r_wait = 0; aw_age = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk); #1;
      if (s_rst) begin
        {got_aw, got_w, b_pend, r_pend} = '0;
        bvalid = 0; rvalid = 0;
      end else begin
        if (s_awv && !(s_awr && s_en)) begin
          chk("aw_hold", 64'(awvalid), 64'(1)); chk("awaddr_hold", 64'(awaddr), 64'(s_awaddr));
        end
        if (s_wv && !(s_wr && s_en)) begin
          chk("w_hold", 64'(wvalid), 64'(1)); chk("wdata_hold", 64'(wdata), 64'(s_wdata));
          chk("wstrb_hold", 64'(wstrb), 64'(s_wstrb));
        end
        if (s_arv && !(s_arr && s_en)) begin
          chk("ar_hold", 64'(arvalid), 64'(1)); chk("araddr_hold", 64'(araddr), 64'(s_araddr));
        end
        if (s_awv && s_awr && s_en) begin
          chk("aw_drop", 64'(awvalid), 64'(0));
          got_aw = 1; c_a = s_awaddr; aw_age = 0; aw_cnt++;
        end else if (got_aw) aw_age++;
        if (s_wv && s_wr && s_en) begin
          chk("w_drop", 64'(wvalid), 64'(0));
          got_w = 1; c_d = s_wdata; c_s = s_wstrb;
        end
        if (s_bv && s_br && s_en) begin
          chk("b_drop", 64'(bready), 64'(0)); bvalid = 0; b_pend = 0;
        end
        if (s_rv && s_rr && s_en) begin
          chk("r_drop", 64'(rready), 64'(0)); rvalid = 0; r_pend = 0;
        end
        if (s_arv && s_arr && s_en) begin
          chk("ar_drop", 64'(arvalid), 64'(0));
          ar_cnt++; r_pend = 1; r_wait = int'($urandom_range(dly_max, dly_min));
          rdata = rd_fixed_en ? rd_fixed : DW'($urandom);
          rresp = r_resp_plan;
          rd_q.push_back('{rdata, rresp});
        end
        if (got_aw && got_w && !b_pend) begin
          b_pend = 1; b_wait = int'($urandom_range(dly_max, dly_min));
          got_aw = 0; got_w = 0; bresp = b_resp_plan;
          wr_q.push_back('{c_a, c_d, c_s, b_resp_plan});
        end
        if (b_pend && !bvalid) begin
          if (b_wait == 0) bvalid = 1; else b_wait--;
        end
        if (r_pend && !rvalid) begin
          if (r_wait == 0) rvalid = 1; else r_wait--;
        end
        if (awvalid) chk("awprot", 64'(awprot), 64'(0));
        if (arvalid) chk("arprot", 64'(arprot), 64'(0));
      end
      awready = ($urandom_range(99, 0) < rdy_pct);
      wready  = (w_lag > 0) ? (got_aw && aw_age >= w_lag - 1) : ($urandom_range(99, 0) < rdy_pct);
      arready = ar_hold ? 1'b0 : ($urandom_range(99, 0) < rdy_pct);
      s_awv = awvalid; s_awr = awready; s_wv = wvalid; s_wr = wready;
      s_bv = bvalid; s_br = bready; s_arv = arvalid; s_arr = arready;
      s_rv = rvalid; s_rr = rready; s_en = cke; s_rst = rst;
      s_awaddr = awaddr; s_araddr = araddr; s_wdata = wdata; s_wstrb = wstrb;
    end
  end

  // One IOb transaction, called at a falling edge. lat_exp 0 skips the timing check;
  // a read's latency counts the accept cycle and the pulse cycle, a write's is
  // the number of cycles after accept until iob_ready_o is high again.
  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input bit hold, input bit stall,
                     input bit rnd_cke, input int lat_exp);
    int n, errs_seen, lat;
    bit done;
    wr_t w;
    rd_t r;
    iob_avalid = 1; iob_addr = a; iob_wdata = d; iob_wstrb = we ? s : '0;
    n = 0;
    while (!iob_ready && n < 100) begin @(negedge clk); n++; end
    if (!iob_ready) begin chk("accept_timeout", 64'(0), 64'(1)); iob_avalid = 0; return; end
    cke = 1;
    @(negedge clk);
    if (!hold) iob_avalid = 0;
    if (stall) begin
      n = 0;
      while (!arvalid && n < 20) begin @(negedge clk); n++; end
      cke = 0;
      repeat (5) begin
        @(negedge clk);
        chk("stall_arvalid", 64'(arvalid), 64'(1));
        chk("stall_araddr", 64'(araddr), 64'(a));
      end
      cke = 1; ar_hold = 0;
    end
    done = 0; n = 1; errs_seen = 0;
    while (!done && n < 300) begin
      if (we ? iob_ready : iob_rvalid) done = 1;
      else begin
        if (we) begin
          chk("wr_no_rvalid", 64'(iob_rvalid), 64'(0));
          chk("bready_early", 64'(bready && (awvalid || wvalid)), 64'(0));
        end
        if (err) errs_seen++;
        if (rnd_cke) cke = ($urandom_range(3, 0) != 0);
        @(negedge clk); n++;
      end
    end
    cke = 1;
    if (!done) begin chk("done_timeout", 64'(0), 64'(1)); return; end
    lat = we ? n : n + 1;
    if (lat_exp > 0) chk(we ? "wr_latency" : "rd_latency", 64'(lat), 64'(lat_exp));
    chk("err_early", 64'(errs_seen), 64'(0));
    if (we) begin
      if (wr_q.size() == 0) chk("wr_missing", 64'(0), 64'(1));
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(w.a), 64'(a));
        chk("wr_data", 64'(w.d), 64'(d));
        chk("wr_strb", 64'(w.s), 64'(s));
        chk("wr_err", 64'(err), 64'(w.resp != 2'b00));
      end
      chk("rdata_stable", 64'(iob_rdata), 64'(last_rd));
      chk("wr_rvalid_end", 64'(iob_rvalid), 64'(0));
    end else begin
      if (rd_q.size() == 0) chk("rd_missing", 64'(0), 64'(1));
      else begin
        r = rd_q.pop_front();
        chk("rd_data", 64'(iob_rdata), 64'(r.d));
        chk("rd_err", 64'(err), 64'(r.resp != 2'b00));
        last_rd = r.d;
      end
      chk("rd_idle", 64'(iob_ready), 64'(1));
    end
  endtask

  initial begin : main
    int ar0, aw0;
    logic we;
    logic [SW-1:0] s;
    rst = 1; cke = 0; iob_avalid = 0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
    repeat (3) @(negedge clk);
    // reset must apply even with the clock enable low
    chk("rst_ready", 64'(iob_ready), 64'(1));
    chk("rst_rvalid", 64'(iob_rvalid), 64'(0));
    chk("rst_rdata", 64'(iob_rdata), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_valids", 64'({awvalid, wvalid, arvalid}), 64'(0));
    chk("rst_readies", 64'({bready, rready}), 64'(0));
    rst = 0; cke = 1;
    @(negedge clk);

    rd_fixed_en = 1; rd_fixed = 32'hDEADBEEF;
    txn(0, 32'h10, '0, '0, 0, 0, 0, 4);
    chk("rd_deadbeef", 64'(iob_rdata), 64'(32'hDEADBEEF));
    @(negedge clk);
    chk("rvalid_single", 64'(iob_rvalid), 64'(0));
    rd_fixed_en = 0;

    txn(1, 32'h24, 32'hA5A50001, 4'hF, 0, 0, 0, 3);

    w_lag = 3;
    txn(1, 32'h20, 32'h12345678, 4'hF, 0, 0, 0, 6);
    w_lag = 0;

    b_resp_plan = 2'b10;
    txn(1, 32'h30, 32'h0BAD0030, 4'h1, 0, 0, 0, 3);
    @(negedge clk);
    chk("err_one_cycle", 64'(err), 64'(0));
    chk("err_wr_rvalid", 64'(iob_rvalid), 64'(0));
    chk("err_ready", 64'(iob_ready), 64'(1));
    b_resp_plan = 2'b00;

    ar0 = ar_cnt; aw0 = aw_cnt;
    txn(0, 32'h40, '0, '0, 1, 0, 0, 4);
    chk("b2b_one_read", 64'(ar_cnt), 64'(ar0 + 1));
    chk("b2b_no_write_yet", 64'(aw_cnt), 64'(aw0));
    txn(1, 32'h44, 32'hCAFE0044, 4'h3, 0, 0, 0, 3);
    chk("b2b_reads", 64'(ar_cnt), 64'(ar0 + 1));
    chk("b2b_writes", 64'(aw_cnt), 64'(aw0 + 1));

    ar_hold = 1;
    txn(0, 32'h50, '0, '0, 0, 1, 0, 0);

    // reset while waiting in the read-data phase
    dly_min = 6; dly_max = 6;
    iob_avalid = 1; iob_addr = 32'h60; iob_wstrb = '0;
    @(negedge clk);
    iob_avalid = 0;
    for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
    chk("rst_in_rd_data", 64'(rready), 64'(1));
    rst = 1;
    @(negedge clk);
    chk("mid_rst_valids", 64'({awvalid, wvalid, arvalid}), 64'(0));
    chk("mid_rst_readies", 64'({bready, rready}), 64'(0));
    chk("mid_rst_ready", 64'(iob_ready), 64'(1));
    chk("mid_rst_rvalid", 64'(iob_rvalid), 64'(0));
    chk("mid_rst_rdata", 64'(iob_rdata), 64'(0));
    rst = 0; rd_q.delete(); last_rd = '0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_rvalid", 64'(iob_rvalid), 64'(0));
    end
    dly_min = 0; dly_max = 0;

    rdy_pct = 60; dly_min = 0; dly_max = 3;
    for (int i = 0; i < 40; i++) begin
      we = $urandom_range(1, 0) != 0;
      s = SW'($urandom_range(15, 1));
      b_resp_plan = ($urandom_range(3, 0) == 0) ? 2'b10 : 2'b00;
      r_resp_plan = ($urandom_range(3, 0) == 0) ? 2'b11 : 2'b00;
      txn(we, AW'($urandom), DW'($urandom), s, 0, 0, 1, 0);
      if ($urandom_range(1, 0) != 0) @(negedge clk);
    end
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
